// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the wait-state memory responder.
package mem_responder_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;

  localparam int WORD_W    = 32;
  localparam int BYTE_W    = 8;
  localparam int NUM_BYTES = WORD_W / BYTE_W;
  localparam int LAT_MIN   = 1;
  localparam int LAT_MAX   = 15;

  typedef struct packed {
    logic                 wr;
    logic [WORD_W-1:0]    addr;
    logic [NUM_BYTES-1:0] be;
    logic [WORD_W-1:0]    wdata;
  } req_t;
endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between the core's memory port and the responder.
interface mem_responder_if;
  import mem_responder_pkg::*;

  logic                 req_valid;
  logic                 req_ready;
  logic                 req_write;
  logic [WORD_W-1:0]    req_addr;
  logic [NUM_BYTES-1:0] req_be;
  logic [WORD_W-1:0]    req_wdata;
  logic                 rsp_valid;
  logic [WORD_W-1:0]    rsp_rdata;
  logic                 rsp_err;

  modport master (output req_valid, req_write, req_addr, req_be, req_wdata,
                  input  req_ready, rsp_valid, rsp_rdata, rsp_err);
  modport slave  (input  req_valid, req_write, req_addr, req_be, req_wdata,
                  output req_ready, rsp_valid, rsp_rdata, rsp_err);
endinterface

// File: rtl/mem_responder_array_sp.sv
// Single-port word array: byte-lane writes, registered read, no reset.
module mem_array_sp
  import mem_responder_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 en,
  input  logic                 we,
  input  logic [NUM_BYTES-1:0] be,
  input  logic [AW-1:0]        addr,
  input  logic [WORD_W-1:0]    wdata,
  output logic [WORD_W-1:0]    rdata
);
  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] rdata_q;

  // Read data only moves on an enabled read, so it holds across writes.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < NUM_BYTES; i++)
          if (be[i]) mem_q[addr][i*BYTE_W +: BYTE_W] <= wdata[i*BYTE_W +: BYTE_W];
      end else begin
        rdata_q <= mem_q[addr];
      end
    end
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder: accepts one request, waits, then pulses a response.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic clk,
  input  logic rst_n,
  mem_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(LATENCY + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(LATENCY - 1);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  req_t              hold_q, hold_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rd_zero_q, rd_zero_d;
  logic              accept, bad_addr, fire;
  logic [WORD_W-1:0] arr_rdata;

  assign accept   = bus.req_valid && (state_q == ST_IDLE);
  assign bad_addr = (hold_q.addr[1:0] != 2'b00) || (hold_q.addr[WORD_W-1:AW+2] != '0);
  assign fire     = (state_q == ST_RESP);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rd_zero_d   = rd_zero_q;
    unique case (state_q)
      ST_IDLE: if (accept) begin
        hold_d  = '{wr: bus.req_write, addr: bus.req_addr, be: bus.req_be, wdata: bus.req_wdata};
        state_d = (LATENCY > 1) ? ST_WAIT : ST_RESP;
        cnt_d   = (LATENCY > 1) ? CW'(1) : '0;
      end
      ST_WAIT: begin
        if (cnt_q >= CNT_LAST) state_d = ST_RESP;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      ST_RESP: begin
        state_d     = ST_IDLE;
        cnt_d       = '0;
        rsp_valid_d = 1'b1;
        rsp_err_d   = bad_addr;
        // Errors force zero read data; writes leave the last read value visible.
        if (bad_addr)       rd_zero_d = 1'b1;
        else if (!hold_q.wr) rd_zero_d = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      hold_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rd_zero_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rd_zero_q   <= rd_zero_d;
    end
  end

  mem_array_sp #(.DEPTH(DEPTH), .AW(AW)) u_array (
    .clk   (clk),
    .en    (fire && !bad_addr),
    .we    (hold_q.wr),
    .be    (hold_q.be),
    .addr  (hold_q.addr[AW+1:2]),
    .wdata (hold_q.wdata),
    .rdata (arr_rdata)
  );

  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rd_zero_q ? '0 : arr_rdata;
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: a LATENCY=2 and a LATENCY=1 instance against a per-cycle reference model.
module tb_mem_responder;
  localparam int DEPTH = 64;
  localparam int L0 = 2;
  localparam int L1 = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  v = 2'b00;
  logic        wr = 1'b0;
  logic [31:0] ad = '0, wd = '0;
  logic [3:0]  bea = '0;
  logic [1:0]  rdy, rv, re;
  logic [31:0] rd [2];

  mem_responder_if bus0();
  mem_responder_if bus1();

  assign bus0.req_valid = v[0];
  assign bus0.req_write = wr;
  assign bus0.req_addr  = ad;
  assign bus0.req_be    = bea;
  assign bus0.req_wdata = wd;
  assign bus1.req_valid = v[1];
  assign bus1.req_write = wr;
  assign bus1.req_addr  = ad;
  assign bus1.req_be    = bea;
  assign bus1.req_wdata = wd;
  assign rdy   = {bus1.req_ready, bus0.req_ready};
  assign rv    = {bus1.rsp_valid, bus0.rsp_valid};
  assign re    = {bus1.rsp_err, bus0.rsp_err};
  assign rd[0] = bus0.rsp_rdata;
  assign rd[1] = bus1.rsp_rdata;

  mem_responder #(.DEPTH(DEPTH), .LATENCY(L0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
  mem_responder #(.DEPTH(DEPTH), .LATENCY(L1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %h, expected %h (t=%0t)", nm, idx, act, exp, $time);
    end
  endtask

  function automatic int lat_of(input int k);
    return (k == 0) ? L0 : L1;
  endfunction

  // Reference model: busy for LATENCY edges after an accept, then the access
  // happens and a one-cycle response is expected. Memory modelled per byte.
  logic [31:0] mmem [2][DEPTH];
  bit   [3:0]  kn   [2][DEPTH];
  bit          busy [2];
  int          rem  [2];
  logic        hw   [2];
  logic [31:0] ha [2], hd [2];
  logic [3:0]  hb   [2];
  bit          e_vld [2], e_err [2], rd_kn [2];
  logic [31:0] e_rd [2];

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        busy[k] = 0; e_vld[k] = 0; e_err[k] = 0; e_rd[k] = '0; rd_kn[k] = 1;
      end else begin
        e_vld[k] = 0;
        e_err[k] = 0;
        if (busy[k]) begin
          rem[k]--;
          if (rem[k] == 0) begin
            busy[k] = 0;
            e_vld[k] = 1;
            if (ha[k][1:0] != 2'b00 || ha[k][31:2] >= 30'(DEPTH)) begin
              e_err[k] = 1; e_rd[k] = '0; rd_kn[k] = 1;
            end else if (hw[k]) begin
              for (int i = 0; i < 4; i++)
                if (hb[k][i]) begin
                  mmem[k][ha[k][31:2]][i*8 +: 8] = hd[k][i*8 +: 8];
                  kn[k][ha[k][31:2]][i] = 1;
                end
            end else begin
              e_rd[k]  = mmem[k][ha[k][31:2]];
              rd_kn[k] = (kn[k][ha[k][31:2]] == 4'hF);
            end
          end
        end else if (v[k]) begin
          busy[k] = 1; rem[k] = lat_of(k);
          hw[k] = wr; ha[k] = ad; hb[k] = bea; hd[k] = wd;
        end
      end
    end
  end

  always @(negedge clk) begin
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("m_ready", k, 32'(rdy[k]), 32'(!busy[k]));
      chk("m_rsp_valid", k, 32'(rv[k]), 32'(e_vld[k]));
      chk("m_rsp_err", k, 32'(re[k]), 32'(e_err[k]));
      if (rd_kn[k]) chk("m_rsp_rdata", k, rd[k], e_rd[k]);
    end
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic chk_idle(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk({tag, "_ready"}, k, 32'(rdy[k]), 32'd1);
      chk({tag, "_rsp_valid"}, k, 32'(rv[k]), 32'd0);
      chk({tag, "_rsp_err"}, k, 32'(re[k]), 32'd0);
      chk({tag, "_rsp_rdata"}, k, rd[k], 32'd0);
    end
  endtask

  task automatic xact(input int k, input logic w, input logic [31:0] a, input logic [3:0] b,
                      input logic [31:0] d, output bit got, output logic e,
                      output logic [31:0] r, output int lat);
    int n = 0;
    while (!rdy[k] && n < 20) begin tick(); n++; end
    wr = w; ad = a; bea = b; wd = d; v[k] = 1'b1;
    tick();
    v[k] = 1'b0;
    got = 0; lat = 0; e = 1'bx; r = 'x;
    for (int i = 1; i <= 20 && !got; i++) begin
      if (rv[k]) begin got = 1; lat = i - 1; e = re[k]; r = rd[k]; end
      else tick();
    end
  endtask

  typedef struct {
    int          k;
    logic        w;
    logic [31:0] a;
    logic [3:0]  b;
    logic [31:0] d;
    logic        ee;
    logic [31:0] er;
  } vec_t;

  task automatic run_vec(input vec_t t, input int idx);
    bit got; logic e; logic [31:0] r; int lat;
    xact(t.k, t.w, t.a, t.b, t.d, got, e, r, lat);
    chk("rsp_seen", idx, 32'(got), 32'd1);
    if (got) begin
      chk("latency", idx, 32'(lat), 32'(lat_of(t.k)));
      chk("rsp_err", idx, 32'(e), 32'(t.ee));
      if (!t.w || t.ee) chk("rsp_rdata", idx, r, t.er);
    end
  endtask

  initial begin
    vec_t tbl [$];
    int cnt;
    tbl.push_back('{0, 1'b1, 32'h10,  4'hF, 32'hDEADBEEF, 1'b0, 32'h0});
    tbl.push_back('{0, 1'b0, 32'h10,  4'h0, 32'h0,        1'b0, 32'hDEADBEEF});
    tbl.push_back('{0, 1'b1, 32'h10,  4'h2, 32'h0000AB00, 1'b0, 32'h0});
    tbl.push_back('{0, 1'b0, 32'h10,  4'h0, 32'h0,        1'b0, 32'hDEADABEF});
    tbl.push_back('{0, 1'b0, 32'h13,  4'h0, 32'h0,        1'b1, 32'h0});
    tbl.push_back('{0, 1'b0, 32'h100, 4'h0, 32'h0,        1'b1, 32'h0});
    tbl.push_back('{0, 1'b0, 32'h10,  4'h0, 32'h0,        1'b0, 32'hDEADABEF});
    tbl.push_back('{0, 1'b1, 32'h14,  4'hF, 32'hCAFEF00D, 1'b0, 32'h0});
    tbl.push_back('{0, 1'b1, 32'h14,  4'h0, 32'h12345678, 1'b0, 32'h0});
    tbl.push_back('{0, 1'b0, 32'h14,  4'h0, 32'h0,        1'b0, 32'hCAFEF00D});
    tbl.push_back('{0, 1'b1, 32'hFC,  4'hF, 32'hA5A5A5A5, 1'b0, 32'h0});
    tbl.push_back('{0, 1'b0, 32'hFC,  4'h0, 32'h0,        1'b0, 32'hA5A5A5A5});
    tbl.push_back('{0, 1'b1, 32'h100, 4'hF, 32'h77777777, 1'b1, 32'h0});
    tbl.push_back('{0, 1'b0, 32'h80000010, 4'h0, 32'h0,   1'b1, 32'h0});
    tbl.push_back('{0, 1'b1, 32'h20,  4'hF, 32'h11223344, 1'b0, 32'h0});
    tbl.push_back('{1, 1'b1, 32'h10,  4'hF, 32'h0BADF00D, 1'b0, 32'h0});
    tbl.push_back('{1, 1'b0, 32'h10,  4'h0, 32'h0,        1'b0, 32'h0BADF00D});
    tbl.push_back('{1, 1'b0, 32'h11,  4'h0, 32'h0,        1'b1, 32'h0});
    tbl.push_back('{1, 1'b0, 32'h10,  4'h0, 32'h0,        1'b0, 32'h0BADF00D});

    // Reset held three cycles, then idle
    repeat (3) tick();
    chk_idle("rst_held");
    rst_n = 1'b1;
    tick();
    chk_idle("post_rst");

    foreach (tbl[i]) run_vec(tbl[i], i);

    // req_valid held high: one accept per LATENCY+1 cycles
    tick();
    v[0] = 1'b1; wr = 1'b0;
    cnt = 0;
    for (int c = 0; c < 18; c++) begin
      if (c == 12) v[0] = 1'b0;
      ad = 32'($urandom_range(0, 15)) << 2;
      tick();
      if (rv[0]) cnt++;
    end
    chk("held_valid_rsps", 0, 32'(cnt), 32'd4);

    // Reset during WAIT drops the pending write and its response
    wr = 1'b1; ad = 32'h20; bea = 4'hF; wd = 32'h55555555; v[0] = 1'b1;
    tick();
    v[0] = 1'b0;
    rst_n = 1'b0;
    cnt = 0;
    repeat (3) begin tick(); if (rv[0]) cnt++; end
    chk("rst_mid_rsps", 0, 32'(cnt), 32'd0);
    rst_n = 1'b1;
    tick();
    chk_idle("rst_mid");
    run_vec('{0, 1'b0, 32'h20, 4'h0, 32'h0, 1'b0, 32'h11223344}, 100);

    // Randomized traffic on both instances, occasional resets
    for (int c = 0; c < 1500; c++) begin
      v   = 2'($urandom_range(0, 3));
      wr  = 1'($urandom_range(0, 1));
      bea = 4'($urandom);
      wd  = $urandom;
      case ($urandom_range(0, 9))
        0:       ad = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
        1:       ad = 32'(DEPTH * 4) + (32'($urandom_range(0, 15)) << 2);
        2:       ad = $urandom | 32'h80000000;
        default: ad = 32'($urandom_range(0, 15)) << 2;
      endcase
      rst_n = ($urandom_range(0, 299) != 0);
      tick();
    end
    v = 2'b00;
    rst_n = 1'b1;
    repeat (5) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
